// File: rtl/mmio_regbank_if.sv
// Processor data-memory port as seen by the MMIO bank, including the RAM data/write-enable side.
interface mmio_regbank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic              wren;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] q_dmem;
  logic              ram_wEn;
  logic [DATA_W-1:0] ram_dataOut;

  modport master (
    output wren, address_dmem, data, ram_dataOut,
    input  q_dmem, ram_wEn
  );

  modport slave (
    input  wren, address_dmem, data, ram_dataOut,
    output q_dmem, ram_wEn
  );
endinterface

// File: rtl/mmio_regbank.sv
// Memory-mapped output registers and input capture channels sitting in front of the data RAM.
// Window reads are registered so they line up with the 1-cycle RAM latency.
module mmio_regbank #(
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 12,
  parameter int              N_OUT     = 4,
  parameter int              N_IN      = 4,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 12'hF00
) (
  input  logic                    clock,
  input  logic                    reset,
  mmio_regbank_if.slave           bus,
  output logic [N_OUT*DATA_W-1:0] out_regs,
  output logic [N_OUT-1:0]        out_strobe,
  input  logic [N_IN*DATA_W-1:0]  in_vals,
  input  logic [N_IN-1:0]         in_valid,
  output logic                    irq
);

  logic [DATA_W-1:0] r_out [N_OUT];
  logic [DATA_W-1:0] r_cap [N_IN];
  logic [N_IN-1:0]   r_status;
  logic [N_IN-1:0]   r_mask;
  logic [N_IN-1:0]   r_ovr;
  logic [N_OUT-1:0]  r_strobe;
  logic              r_irq;
  logic              r_selQ;
  logic [DATA_W-1:0] r_rdQ;

  logic              w_hit;
  logic [7:0]        w_off;
  logic              w_wrHit;
  logic [DATA_W-1:0] w_rdMux;
  logic [N_IN-1:0]   w_statusClr;
  logic [N_IN-1:0]   w_ovrClr;
  logic [N_IN-1:0]   w_statusNext;
  logic [N_IN-1:0]   w_maskNext;
  logic [N_IN-1:0]   w_ovrNext;

  assign w_hit       = (bus.address_dmem[ADDR_W-1:8] == MMIO_BASE[ADDR_W-1:8]);
  assign w_off       = bus.address_dmem[7:0];
  assign w_wrHit     = bus.wren & w_hit;
  assign bus.ram_wEn = bus.wren & ~w_hit;
  assign bus.q_dmem  = r_selQ ? r_rdQ : bus.ram_dataOut;
  assign out_strobe  = r_strobe;
  assign irq         = r_irq;

  always_comb begin
    out_regs = '0;
    for (int i = 0; i < N_OUT; i++) begin
      out_regs[i*DATA_W +: DATA_W] = r_out[i];
    end
  end

  // Read mux samples current register values; unmapped offsets read as zero.
  always_comb begin
    w_rdMux = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (w_off == 8'(i)) w_rdMux = r_out[i];
    end
    for (int i = 0; i < N_IN; i++) begin
      if (w_off == 8'(64 + i)) w_rdMux = r_cap[i];
    end
    case (w_off)
      8'h80:   w_rdMux = DATA_W'(r_status);
      8'h81:   w_rdMux = DATA_W'(r_mask);
      8'h82:   w_rdMux = DATA_W'(r_ovr);
      default: ;
    endcase
  end

  // Captures are OR-ed in after the clear so a same-edge set wins.
  always_comb begin
    w_statusClr  = (w_wrHit && w_off == 8'h80) ? bus.data[N_IN-1:0] : '0;
    w_ovrClr     = (w_wrHit && w_off == 8'h82) ? bus.data[N_IN-1:0] : '0;
    w_maskNext   = (w_wrHit && w_off == 8'h81) ? bus.data[N_IN-1:0] : r_mask;
    w_statusNext = (r_status & ~w_statusClr) | in_valid;
    w_ovrNext    = (r_ovr & ~w_ovrClr) | (r_status & in_valid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) r_out[i] <= '0;
      for (int i = 0; i < N_IN; i++)  r_cap[i] <= '0;
      r_status <= '0;
      r_mask   <= '0;
      r_ovr    <= '0;
      r_strobe <= '0;
      r_irq    <= 1'b0;
      r_selQ   <= 1'b0;
      r_rdQ    <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        r_strobe[i] <= w_wrHit && (w_off == 8'(i));
        if (w_wrHit && (w_off == 8'(i))) r_out[i] <= bus.data;
      end
      for (int i = 0; i < N_IN; i++) begin
        if (in_valid[i]) r_cap[i] <= in_vals[i*DATA_W +: DATA_W];
      end
      r_status <= w_statusNext;
      r_mask   <= w_maskNext;
      r_ovr    <= w_ovrNext;
      r_irq    <= |(w_statusNext & w_maskNext);
      r_selQ   <= w_hit;
      r_rdQ    <= w_rdMux;
    end
  end

endmodule

// File: doc/mmio_regbank.md
Name: mmio_regbank

Overview:
Parametrised memory-mapped I/O bank between the processor data-memory port and the data RAM. It replaces hard-wired register-file taps with N_OUT writable output registers and N_IN input capture channels, all at a fixed address window. Input channels have sticky new-data and overrun flags and a maskable interrupt. All non-window traffic passes through to the RAM unchanged.

Parameters:
DATA_W, 32, data word width
ADDR_W, 12, processor data address width (address bits used)
N_OUT, 4, output registers (1..64)
N_IN, 4, input capture channels (1..32, and ≤ DATA_W)
MMIO_BASE, 12'hF00, window base; bits [7:0] must be 0

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
wren  in  1  processor data write enable
address_dmem  in  ADDR_W  processor data address
data  in  DATA_W  processor write data
q_dmem  out  DATA_W  read data to processor
ram_wEn  out  1  RAM write enable
ram_dataOut  in  DATA_W  RAM read data (1-cycle synchronous RAM)
out_regs  out  N_OUT*DATA_W  output register contents, channel i at [i*DATA_W +: DATA_W]
out_strobe  out  N_OUT  1-cycle pulse per output register write
in_vals  in  N_IN*DATA_W  peripheral values, channel i at [i*DATA_W +: DATA_W]
in_valid  in  N_IN  per-channel capture pulse
irq  out  1  interrupt request, level

Behaviour:
- Clock and reset: single clock `clock`. Reset `reset` is synchronous and active-high. All state updates on the rising edge.
- Decode:
  - hit = (address_dmem[ADDR_W-1:8] == MMIO_BASE[ADDR_W-1:8]); off = address_dmem[7:0].
  - ram_wEn = wren & ~hit (combinational). RAM address and data are wired directly to the processor signals outside this block.
- Register map (offsets):
  - 0x00..N_OUT-1: OUT[i], read/write.
  - 0x40..0x40+N_IN-1: CAP[i], read-only.
  - 0x80: STATUS, new-data flags [N_IN-1:0], write-1-to-clear.
  - 0x81: MASK, read/write, bits [N_IN-1:0].
  - 0x82: OVR, overrun flags, write-1-to-clear.
  - All other offsets: writes ignored, reads return 0. Writes to CAP are ignored. Upper unused bits of STATUS, MASK and OVR read as 0.
- Read path: 1-cycle latency, matching the RAM.
  - Each cycle, register sel_q <= hit and rd_q <= mmio_mux(off).
  - q_dmem = sel_q ? rd_q : ram_dataOut.
  - rd_q samples register values before any same-edge update, so a read of CAP[i] coinciding with in_valid[i] returns the old value.
- OUT write: wren & hit & off==i loads OUT[i] <= data. out_strobe[i] = 1 in the following cycle only. Back-to-back writes produce back-to-back pulses.
- Capture: when in_valid[i] = 1:
  - CAP[i] <= in_vals slice i; STATUS[i] <= 1.
  - If STATUS[i] was already 1 (before any clear this edge), OVR[i] <= 1.
- Clear: a write to 0x80 or 0x82 clears the bits set in data. If a set (in_valid) and a clear hit the same bit on the same edge, the set wins.
- irq: registered, irq <= |(STATUS_next & MASK_next). It asserts the cycle after the flag or mask becomes set and deasserts the cycle after the clear.
- Reset values: OUT, CAP, STATUS, MASK, OVR = 0; out_strobe = 0; irq = 0; rd_q = 0; sel_q = 0 (q_dmem follows RAM). Reset overrides a simultaneous write or capture.
- Reset mid-operation: a pending strobe or read result is discarded, and the read in flight returns RAM data.

Test Plan:
- Reset, then write 0x00000ABC to 0xF01 → out_regs ch1 = 0xABC next cycle, out_strobe = 4'b0010 for exactly one cycle. Read 0xF01 → q_dmem = 0xABC one cycle after the address is presented.
- Write 0x55 to 0x010 (non-window) → ram_wEn = 1, out_regs unchanged. Read 0x010 → q_dmem = RAM data, not rd_q.
- in_valid[2] pulse with in_vals ch2 = 0x1234 → CAP[2] at 0xF42 reads 0x1234, STATUS reads 0x4. Second pulse before clear → OVR reads 0x4.
- MASK = 0x4 and STATUS[2] set → irq = 1 one cycle later. Write 0x4 to 0xF80 → irq = 0 the cycle after. Clear and in_valid[2] on the same edge → STATUS[2] stays 1 and irq stays 1.
- Read 0xF20 and 0xF90 (unmapped) → q_dmem = 0. Write to 0xF40 → CAP[0] unchanged.
- Assert reset in the same cycle as a write to 0xF00 and in_valid[0] → all registers 0, no out_strobe, irq = 0.
